lfsr_lane_picker: RTL

Parametrised multi-channel random lane/value generator for the game-object spawners (obstacles, bananas, future pickups). A single shared Fibonacci LFSR serves up to NUM_CH requesters through a per-channel req/valid handshake. Values are range-limited to 0..LIMIT-1 by rejection sampling, with a bounded-retry fallback. Sits between the spawn controllers and the object position registers.

---
 rtl/lfsr_lane_picker_if.sv | 16 +
 rtl/lfsr_lane_picker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/lfsr_lane_picker_if.sv
// Request/result bundle between spawn controllers (master) and the shared
// random lane picker (slave).
interface lfsr_lane_picker_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 3
);
  logic                    seed_load;
  logic [WIDTH-1:0]        seed_in;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH*OUT_W-1:0] value;

  modport master (output seed_load, seed_in, req, input valid, value);
  modport slave  (input seed_load, seed_in, req, output valid, value);
endinterface

// File: rtl/lfsr_lane_picker.sv
// Shared Fibonacci LFSR serving NUM_CH requesters with range-limited values
// (rejection sampling, bounded retry). Optional feature macro: NO_REPEAT_EN.
module lfsr_lane_picker #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] SEED      = 8'h5A,
  parameter int               OUT_W     = 3,
  parameter int               LIMIT     = 5,
  parameter int               NUM_CH    = 2,
  parameter int               RETRY_MAX = 4
) (
  input logic clk,
  input logic reset,
  lfsr_lane_picker_if.slave bus
);

  localparam int TW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [OUT_W:0]   LIM_EXT   = LIMIT[OUT_W:0];
  localparam logic [OUT_W-1:0] LIM_LO    = LIMIT[OUT_W-1:0];
  localparam logic [RW-1:0]    RETRY_LIM = RETRY_MAX[RW-1:0];

  function automatic logic feedbackBit(input logic [WIDTH-1:0] s);
    return ^(s & TAPS);
  endfunction

  logic [WIDTH-1:0]        lfsrState;
  logic [NUM_CH-1:0]       pend;
  logic [RW-1:0]           retryCnt;
  logic [NUM_CH-1:0]       validR;
  logic [NUM_CH*OUT_W-1:0] valueR;

  logic [TW-1:0]     tgtIdx;
  logic              anyPend;
  logic [OUT_W-1:0]  cand;
  logic              inRange;
  logic              accept;
  logic [OUT_W-1:0]  forcedVal;
  logic              doIssue;
  logic [OUT_W-1:0]  issueVal;
  logic [RW-1:0]     retryNext;
  logic [NUM_CH-1:0] issueMask;

`ifdef NO_REPEAT_EN
  logic [OUT_W-1:0] lastVal [NUM_CH];
  logic [OUT_W-1:0] lastTgt;
  logic [OUT_W:0]   lastInc;
  logic [OUT_W-1:0] lastNext;
  logic [OUT_W-1:0] forcedBase;
  logic             repeatHit;
`endif

  assign bus.valid = validR;
  assign bus.value = valueR;

  // Target selection and accept/retry/force decision for this edge.
  always_comb begin
    tgtIdx = {TW{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      tgtIdx = pend[i] ? TW'(i) : tgtIdx;
    end
    anyPend = |pend;
    cand    = lfsrState[OUT_W-1:0];
    inRange = {1'b0, cand} < LIM_EXT;
`ifdef NO_REPEAT_EN
    lastTgt    = lastVal[tgtIdx];
    lastInc    = {1'b0, lastTgt} + {{OUT_W{1'b0}}, 1'b1};
    lastNext   = (lastInc == LIM_EXT) ? {OUT_W{1'b0}} : lastInc[OUT_W-1:0];
    repeatHit  = (LIMIT != 1) && (cand == lastTgt);
    accept     = inRange && !repeatHit;
    // A candidate can now be rejected while in range; it is then its own base.
    forcedBase = inRange ? cand : (cand - LIM_LO);
    forcedVal  = ((LIMIT != 1) && (forcedBase == lastTgt)) ? lastNext : forcedBase;
`else
    accept     = inRange;
    forcedVal  = cand - LIM_LO;
`endif
    doIssue   = !bus.seed_load && anyPend && (accept || (retryCnt == RETRY_LIM));
    issueVal  = accept ? cand : forcedVal;
    retryNext = (bus.seed_load || !anyPend || doIssue) ? {RW{1'b0}}
                                                       : RW'(retryCnt + 1'b1);
    issueMask = doIssue ? (NUM_CH'(1'b1) << tgtIdx) : {NUM_CH{1'b0}};
  end

  // LFSR advance with seed load priority and all-zero lockup recovery.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsrState <= SEED;
    end else if (bus.seed_load) begin
      lfsrState <= (bus.seed_in == {WIDTH{1'b0}}) ? SEED : bus.seed_in;
    end else if (lfsrState == {WIDTH{1'b0}}) begin
      lfsrState <= SEED;
    end else begin
      lfsrState <= {lfsrState[WIDTH-2:0], feedbackBit(lfsrState)};
    end
  end

  // Pending flags (set wins over clear), retry counter and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= {NUM_CH{1'b0}};
      retryCnt <= {RW{1'b0}};
      validR   <= {NUM_CH{1'b0}};
      valueR   <= {(NUM_CH*OUT_W){1'b0}};
`ifdef NO_REPEAT_EN
      for (int i = 0; i < NUM_CH; i++) begin
        lastVal[i] <= {OUT_W{1'b0}};
      end
`endif
    end else begin
      pend     <= (pend & ~issueMask) | bus.req;
      retryCnt <= retryNext;
      validR   <= issueMask;
      if (doIssue) begin
        valueR[tgtIdx*OUT_W +: OUT_W] <= issueVal;
`ifdef NO_REPEAT_EN
        lastVal[tgtIdx] <= issueVal;
`endif
      end
    end
  end

endmodule
